div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU, beside the ALU in the execute stage.
- Produces quotient (to LO) and remainder (to HI) for the HI/LO write path.
- Holds the pipeline through a stall request while it iterates.
- Supports annul so exception or flush logic can kill an in-flight divide.

---
 rtl/div_unit.sv | 180 ++++++++++++++++++
 tb/tb_div_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU (quotient -> LO, remainder -> HI).
// Latency: DATA_W+1 cycles from start to ready (1 cycle for divide-by-zero); one result per operation.
// Backpressure: raises stall_req to hold the pipeline while iterating; annul kills an operation in flight.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            request a divide (sampled only in IDLE)
//   signed_div       1 = DIV, 0 = DIVU (sampled with start)
//   annul            abort current operation; wins over start and completion
//   a, b             dividend / divisor (sampled with start)
//   stall_req        hold pipeline: start being accepted, or iterating
//   busy             registered, high while iterating
//   ready            one-cycle pulse, hiout/loout valid
//   hiout, loout     remainder / quotient, held until the next result or reset
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic              annul,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              stall_req,
  output logic              busy,
  output logic              ready,
  output logic [DATA_W-1:0] hiout,
  output logic [DATA_W-1:0] loout
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  // dvd_q shifts the dividend out of its MSB while quotient bits shift in at
  // the LSB, so after DATA_W iterations it holds the unsigned quotient.
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              sgn_q, sgn_d;
  logic              dz_q, dz_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] a_abs, b_abs;
  logic [DATA_W:0]   shifted;
  logic [DATA_W+1:0] trial;
  logic              trial_neg;
  logic [DATA_W-1:0] q_fix, r_fix;
  logic              res_vld;

  always_comb begin
    a_abs = (signed_div && a[DATA_W-1]) ? -a : a;
    b_abs = (signed_div && b[DATA_W-1]) ? -b : b;

    // The shifted partial remainder keeps one extra bit: with an unsigned
    // divisor above 2^(DATA_W-1) the remainder's MSB can be set before the
    // shift and must not be lost.
    shifted   = {rem_q, dvd_q[DATA_W-1]};
    trial     = {1'b0, shifted} - {2'b00, dvs_q};
    trial_neg = trial[DATA_W+1];

    // Sign fix-up; a divide-by-zero result is delivered raw.
    q_fix = (sgn_q && !dz_q && (sa_q ^ sb_q)) ? -dvd_q : dvd_q;
    r_fix = (sgn_q && !dz_q && sa_q) ? -rem_q : rem_q;

    res_vld = (state_q == S_DONE) && !annul;
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sgn_d   = sgn_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (start && !annul) begin
          sa_d  = a[DATA_W-1];
          sb_d  = b[DATA_W-1];
          sgn_d = signed_div;
          dvs_d = b_abs;
          cnt_d = '0;
          if (b == '0) begin
            // Divide by zero: all-ones quotient, remainder is a untouched.
            dz_d    = 1'b1;
            dvd_d   = '1;
            rem_d   = a;
            state_d = S_DONE;
          end else begin
            dz_d    = 1'b0;
            dvd_d   = a_abs;
            rem_d   = '0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          rem_d = trial_neg ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
          dvd_d = {dvd_q[DATA_W-2:0], ~trial_neg};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (res_vld) begin
          hi_d = r_fix;
          lo_d = q_fix;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      sgn_q   <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sgn_q   <= sgn_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
    end
  end

  // Results are shown combinationally in the DONE cycle so the pipeline can
  // consume them while ready is high; the held copy takes over afterwards.
  assign ready     = res_vld;
  assign hiout     = res_vld ? r_fix : hi_q;
  assign loout     = res_vld ? q_fix : lo_q;
  assign busy      = busy_q;
  assign stall_req = ((state_q == S_IDLE) && start && !annul) || (state_q == S_BUSY);

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed-vector bench for div_unit.
// Latency: checks ready timing relative to the start cycle.
// Backpressure: checks stall_req across each operation.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall_req;
  logic        busy;
  logic        ready;
  logic [31:0] hiout;
  logic [31:0] loout;

  int n_checks;
  int n_errors;
  int ready_cnt;

  div_unit #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .annul     (annul),
    .a         (a),
    .b         (b),
    .stall_req (stall_req),
    .busy      (busy),
    .ready     (ready),
    .hiout     (hiout),
    .loout     (loout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ready) ready_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start a divide, optionally re-assert start with other operands at
  // poke_cyc, and check latency, results, stall_req and post-result hold.
  task automatic run_div(input string tag, input logic [31:0] da, input logic [31:0] db,
                         input logic sg, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input int exp_lat, input int poke_cyc);
    int          lat;
    logic        stall_ok;
    logic [31:0] got_lo;
    logic [31:0] got_hi;
    lat      = -1;
    stall_ok = 1'b1;
    got_lo   = '0;
    got_hi   = '0;
    @(posedge clk); #1;
    start = 1'b1; a = da; b = db; signed_div = sg;
    for (int cyc = 0; cyc <= 40 && lat < 0; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (cyc == poke_cyc) begin
          start = 1'b1; a = 32'd50; b = 32'd5; signed_div = ~sg;
        end
      end
      @(negedge clk);
      if (ready) begin
        lat    = cyc;
        got_lo = loout;
        got_hi = hiout;
        if (stall_req) stall_ok = 1'b0;
      end else if (!stall_req) begin
        stall_ok = 1'b0;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_lo"}, got_lo, exp_lo);
    check({tag, "_hi"}, got_hi, exp_hi);
    check({tag, "_stall"}, {31'b0, stall_ok}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after"}, {31'b0, ready}, 32'd0);
    check({tag, "_lo_hold"}, loout, exp_lo);
    check({tag, "_hi_hold"}, hiout, exp_hi);
  endtask

  initial begin
    int rc0;
    n_checks   = 0;
    n_errors   = 0;
    ready_cnt  = 0;
    rst        = 1'b1;
    start      = 1'b0;
    signed_div = 1'b0;
    annul      = 1'b0;
    a          = '0;
    b          = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_stall", {31'b0, stall_req}, 32'd0);
    check("rst_hi", hiout, 32'd0);
    check("rst_lo", loout, 32'd0);

    run_div("u7_2", 32'd7, 32'd2, 1'b0, 32'd3, 32'd1, 33, -1);

    // start and annul together in IDLE: nothing happens
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b1; a = 32'd9; b = 32'd3; signed_div = 1'b0;
    @(negedge clk);
    check("sa_stall", {31'b0, stall_req}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    check("sa_busy", {31'b0, busy}, 32'd0);
    check("sa_ready", {31'b0, ready}, 32'd0);
    check("sa_lo", loout, 32'd3);

    // annul at cycle 10 of a divide
    #1 rc0 = ready_cnt;
    @(posedge clk); #1;
    start = 1'b1; a = 32'd1000; b = 32'd3; signed_div = 1'b0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      annul = (cyc == 10);
    end
    @(negedge clk);
    check("annul_busy", {31'b0, busy}, 32'd0);
    check("annul_stall", {31'b0, stall_req}, 32'd0);
    check("annul_lo", loout, 32'd3);
    check("annul_hi", hiout, 32'd1);
    #1 check("annul_no_ready", ready_cnt, rc0);
    run_div("annul_new", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, -1);

    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, -1);
    run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33, -1);
    run_div("dz_u", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1, -1);
    run_div("dz_s", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1, -1);
    run_div("dz_sneg", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1, -1);
    run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33, -1);
    run_div("restart", 32'd200, 32'd9, 1'b0, 32'd22, 32'd2, 33, 5);
    run_div("u_max", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 33, -1);
    run_div("u_bigdvs", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFE, 33, -1);

    // synchronous reset at cycle 20 of a divide
    @(posedge clk); #1;
    start = 1'b1; a = 32'd1000; b = 32'd7; signed_div = 1'b0;
    for (int cyc = 1; cyc <= 21; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst   = (cyc == 20);
    end
    @(negedge clk);
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_ready", {31'b0, ready}, 32'd0);
    check("mrst_stall", {31'b0, stall_req}, 32'd0);
    check("mrst_hi", hiout, 32'd0);
    check("mrst_lo", loout, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
